msrv_32_instr_fetch: RTL and testbench

MSRV_32_INSTR_FETCH -- requirements
Module: msrv_32_instr_fetch

---
 rtl/msrv_32_instr_fetch.sv | 99 +++++++++
 tb/tb_msrv_32_instr_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/msrv_32_instr_fetch.sv
// msrv_32_instr_fetch: instruction fetch with a 2-entry {pc, instr} FIFO feeding decode.
// Optional MSRV32_FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module msrv_32_instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misaligned_out
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {IDLE, REQ, DISCARD, FULL, HALT} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_fifo_pc [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_misaligned;
  logic [31:0] w_target;
  logic        w_bad;
  logic        w_pop;
  logic        w_push;
  logic        w_tail;
  logic [1:0]  w_count_nxt;
  state_t      w_resume;
`ifdef MSRV32_FETCH_MISALIGN_TRAP_EN
  assign w_target       = redirect_pc_in;
  assign w_bad          = |redirect_pc_in[1:0];
  assign misaligned_out = r_misaligned;
`else
  assign w_target       = {redirect_pc_in[31:2], 2'b00};
  assign w_bad          = 1'b0;
  assign misaligned_out = 1'b0;
`endif
  assign w_pop           = instr_valid_out & ~stall_in & ~redirect_in;
  assign w_push          = (r_state == REQ) & imem_ack_in & ~redirect_in;
  assign w_count_nxt     = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_tail          = r_head ^ r_count[0];
  assign w_resume        = w_bad ? HALT : REQ;
  assign imem_req_out    = (r_state == REQ) || (r_state == DISCARD);
  // While discarding, the bus keeps the abandoned address; r_pc already holds the target.
  assign imem_addr_out   = (r_state == DISCARD) ? r_addr : r_pc;
  assign instr_valid_out = r_count != 2'd0;
  assign instr_out       = instr_valid_out ? r_fifo_instr[r_head] : NOP;
  assign pc_out          = instr_valid_out ? r_fifo_pc[r_head] : r_pc;
  assign flush_out       = ~instr_valid_out;
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_push) begin
      r_fifo_pc[w_tail]    <= r_pc;
      r_fifo_instr[w_tail] <= imem_rdata_in;
    end
  end
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_misaligned <= 1'b0;
    end else if (redirect_in) begin
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_pc         <= w_target;
      r_misaligned <= w_bad;
      if (imem_req_out && !imem_ack_in) begin
        r_state <= DISCARD;
        if (r_state == REQ) r_addr <= r_pc;
      end else begin
        r_state <= w_resume;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_pop) r_head <= ~r_head;
      case (r_state)
        IDLE:    r_state <= REQ;
        REQ:     if (imem_ack_in) begin
                   r_pc    <= r_pc + 32'd4;
                   r_state <= (w_count_nxt == 2'd2) ? FULL : REQ;
                 end
        DISCARD: if (imem_ack_in) r_state <= r_misaligned ? HALT : REQ;
        FULL:    if (w_pop) r_state <= REQ;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv_32_instr_fetch.sv
// tb_msrv_32_instr_fetch: random and directed stimulus against a transaction-level fetch model.
module tb_msrv_32_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        stall_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        flush_out;
  logic        misaligned_out;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  logic [63:0] m_q[$];
  bit          m_started;
  bit          m_disc;
  bit          m_mis;

  msrv_32_instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .imem_req_out          (imem_req_out),
    .imem_addr_out         (imem_addr_out),
    .imem_ack_in           (imem_ack_in),
    .imem_rdata_in         (imem_rdata_in),
    .redirect_in           (redirect_in),
    .redirect_pc_in        (redirect_pc_in),
    .stall_in              (stall_in),
    .instr_out             (instr_out),
    .pc_out                (pc_out),
    .instr_valid_out       (instr_valid_out),
    .flush_out             (flush_out),
    .misaligned_out        (misaligned_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Fetch wants the bus once started, unless halted on a misaligned target or two entries are buffered.
  function automatic bit m_req();
    return m_started && (m_disc || (!m_mis && m_q.size() < 2));
  endfunction

  task automatic check_outs();
    bit r;
    r = m_req();
    chk("req", imem_req_out, r);
    if (r) chk("addr", imem_addr_out, m_disc ? m_daddr : m_pc);
    chk("valid", instr_valid_out, m_q.size() != 0);
    chk("instr", instr_out, m_q.size() != 0 ? m_q[0][31:0] : NOP);
    chk("pc", pc_out, m_q.size() != 0 ? m_q[0][63:32] : m_pc);
    chk("flush", flush_out, m_q.size() == 0);
    chk("mis", misaligned_out, m_mis);
  endtask

  task automatic m_step(input bit ack, input logic [31:0] rd, input bit redir, input logic [31:0] rpc, input bit stall);
    bit r;
    logic [31:0] tgt;
    bit badp;
    r = m_req();
`ifdef MSRV32_FETCH_MISALIGN_TRAP_EN
    tgt  = rpc;
    badp = rpc[1:0] != 2'b00;
`else
    tgt  = {rpc[31:2], 2'b00};
    badp = 1'b0;
`endif
    if (redir) begin
      if (r && !ack) begin
        if (!m_disc) m_daddr = m_pc;
        m_disc = 1'b1;
      end else begin
        m_disc = 1'b0;
      end
      m_q.delete();
      m_pc  = tgt;
      m_mis = badp;
    end else begin
      if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
      if (r && ack) begin
        if (m_disc) m_disc = 1'b0;
        else begin
          m_q.push_back({m_pc, rd});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_started = 1'b1;
  endtask

  task automatic cyc(input bit ack, input bit redir, input logic [31:0] rpc, input bit stall);
    logic [31:0] rd;
    bit a;
    rd = $urandom;
    a  = ack && m_req();
    imem_ack_in = a; imem_rdata_in = rd; redirect_in = redir; redirect_pc_in = rpc; stall_in = stall;
    #1 check_outs();
    @(posedge clk);
    m_step(a, rd, redir, rpc, stall);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack_in = 1'b0; redirect_in = 1'b0; stall_in = 1'b0;
    #1;
    chk("rst_req", imem_req_out, 1'b0);
    chk("rst_addr", imem_addr_out, RESET_PC);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_valid", instr_valid_out, 1'b0);
    chk("rst_flush", flush_out, 1'b1);
    chk("rst_mis", misaligned_out, 1'b0);
    m_pc = RESET_PC; m_daddr = RESET_PC; m_q.delete();
    m_started = 1'b0; m_disc = 1'b0; m_mis = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] p;
    @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    chk("full_noreq", imem_req_out, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h10, 0);
    chk("r35_addr", imem_addr_out, 32'h10);
    cyc(0, 1, 32'h200, 0);
    for (int i = 0; i < 2; i++) begin
      chk("r35_hold", imem_addr_out, 32'h10);
      cyc(0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0);
    chk("r35_new", imem_addr_out, 32'h200);
    chk("r35_drop", instr_valid_out, 1'b0);
    cyc(1, 1, 32'h40, 0);
    chk("r36_flush", flush_out, 1'b1);
    chk("r36_addr", imem_addr_out, 32'h40);
    cyc(1, 1, 32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, 0);
    chk("wrap_addr", imem_addr_out, 32'h0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    cyc(1, 1, 32'h102, 0);
`ifdef MSRV32_FETCH_MISALIGN_TRAP_EN
    chk("halt_mis", misaligned_out, 1'b1);
    chk("halt_req", imem_req_out, 1'b0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h100, 0);
    chk("halt_clr", misaligned_out, 1'b0);
`endif
    chk("r38_addr", imem_addr_out, 32'h100);
    chk("r38_req", imem_req_out, 1'b1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b0;
    #1 chk("midrst_req", imem_req_out, 1'b0);
    @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        p = $urandom;
        if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) p[31:4] = '1;
        cyc($urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, p, $urandom_range(0, 9) < 3);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
